// File: rtl/fpu_pkg.sv
// Shared constants, types and the final packing function for the FMUL result packer.
package fpu_pkg;

  localparam logic [7:0]  EXP_MAX  = 8'd255;
  localparam logic [7:0]  EXP_BIAS = 8'd127;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;

  // Bit positions inside the 3-bit {invalid, overflow, underflow} flag vector.
  localparam logic [1:0] FLAG_INVALID   = 2'd2;
  localparam logic [1:0] FLAG_OVERFLOW  = 2'd1;
  localparam logic [1:0] FLAG_UNDERFLOW = 2'd0;

  typedef enum logic [2:0] {
    ClsNormal,
    ClsZero,
    ClsUnder,
    ClsOvf,
    ClsErr
  } cls_e;

  typedef struct packed {
    logic        sign;
    cls_e        cls;
    logic [7:0]  exp;
    logic [23:0] frac;
  } norm_t;

  typedef struct packed {
    logic [31:0] word;
    logic [2:0]  flags;
  } pack_t;

  function automatic pack_t pack_result(norm_t n);
    pack_t r;
    r.word  = '0;
    r.flags = '0;
    case (n.cls)
      ClsErr: begin
        r.word                = QNAN;
        r.flags[FLAG_INVALID] = 1'b1;
      end
      ClsOvf: begin
        r.word                 = {n.sign, EXP_MAX, 23'h0};
        r.flags[FLAG_OVERFLOW] = 1'b1;
      end
      ClsZero: begin
        r.word = {n.sign, 31'h0};
      end
      ClsUnder: begin
        r.word                  = {n.sign, 31'h0};
        r.flags[FLAG_UNDERFLOW] = 1'b1;
      end
      default: begin
        // No rounding: the hidden bit is dropped and the rest truncated.
        r.word = {n.sign, n.exp, n.frac[22:0]};
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fmul_pack_if.sv
// Upstream/downstream handshake and data bundle of the FMUL result packer.
interface fmul_pack_if;

  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [7:0]  in_exp;
  logic [23:0] in_frac;
  logic        in_error;
  logic        in_overflow;

  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_flags;

  modport master (
    output in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    input  in_ready, out_valid, out_word, out_flags
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_frac, in_error, in_overflow, out_ready,
    output in_ready, out_valid, out_word, out_flags
  );

endinterface

// File: rtl/lzc24.sv
// Combinational leading-zero counter for a 24-bit mantissa; all-zero input yields 24.
module lzc24 (
  input  logic [23:0] data_i,
  output logic [4:0]  cnt_o
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    cnt_o = 5'd24;
    for (int i = 0; i < 24; i++) begin
      if (data_i[i]) begin
        cnt_o = 5'(23 - i);
      end
    end
  end

endmodule

// File: rtl/fmul_pack.sv
// Two-stage normalize/pack pipeline turning raw FMUL products into IEEE-754 single words.
module fmul_pack
  import fpu_pkg::*;
(
  input logic        clk,
  input logic        nRESET,
  fmul_pack_if.slave bus
);

  logic  vn_q, vn_d;
  logic  vp_q, vp_d;
  logic  n_adv, p_adv;
  norm_t norm_q, norm_d;
  pack_t pack_q, pack_d;

  logic [4:0]  lz;
  logic [7:0]  lz_ext;
  logic [7:0]  exp_sh;
  logic [23:0] frac_sh;
  logic        frac_zero;
  logic        shiftable;

  lzc24 u_lzc (
    .data_i (bus.in_frac),
    .cnt_o  (lz)
  );

  // Handshake: each stage moves when it is empty or its successor moves.
  always_comb begin
    p_adv = !vp_q || bus.out_ready;
    n_adv = !vn_q || p_adv;
    vn_d  = n_adv ? bus.in_valid : vn_q;
    vp_d  = p_adv ? vn_q : vp_q;
  end

  // Stage N: normalize and classify.
  always_comb begin
    lz_ext    = {3'b000, lz};
    exp_sh    = bus.in_exp - lz_ext;
    frac_sh   = bus.in_frac << lz;
    frac_zero = (bus.in_frac == 24'h0);
    shiftable = !frac_zero && (bus.in_exp > lz_ext);

    norm_d.sign = bus.in_sign;
    norm_d.exp  = exp_sh;
    norm_d.frac = frac_sh;
    if (bus.in_error) begin
      norm_d.cls = ClsErr;
    end else if (bus.in_overflow || (shiftable && (exp_sh == EXP_MAX))) begin
      norm_d.cls = ClsOvf;
    end else if (frac_zero) begin
      norm_d.cls = ClsZero;
    end else if (!shiftable) begin
      norm_d.cls = ClsUnder;
    end else begin
      norm_d.cls = ClsNormal;
    end
  end

  // Stage P: assemble the output word from the registered classification.
  always_comb begin
    pack_d = pack_result(norm_q);
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      vn_q   <= 1'b0;
      vp_q   <= 1'b0;
      norm_q <= '0;
      pack_q <= '0;
    end else begin
      vn_q <= vn_d;
      vp_q <= vp_d;
      if (n_adv) begin
        norm_q <= norm_d;
      end
      if (p_adv) begin
        pack_q <= pack_d;
      end
    end
  end

  assign bus.in_ready  = n_adv;
  assign bus.out_valid = vp_q;
  assign bus.out_word  = pack_q.word;
  assign bus.out_flags = pack_q.flags;

endmodule

// File: tb/tb_fmul_pack.sv
// Directed self-checking bench for fmul_pack: packing cases, latency, backpressure, reset.
module tb_fmul_pack;

  logic clk;
  logic nRESET;
  int   n_total;
  int   n_bad;

  fmul_pack_if bus ();

  fmul_pack dut (
    .clk    (clk),
    .nRESET (nRESET),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [23:0] f,
                       input logic err, input logic ovf);
    bus.in_valid    = 1'b1;
    bus.in_sign     = s;
    bus.in_exp      = e;
    bus.in_frac     = f;
    bus.in_error    = err;
    bus.in_overflow = ovf;
  endtask

  // One isolated transfer with out_ready held high; checks 2-cycle latency and result.
  task automatic send_one(input string tag, input logic s, input logic [7:0] e,
                          input logic [23:0] f, input logic err, input logic ovf,
                          input logic [31:0] w, input logic [2:0] fl);
    @(negedge clk);
    drive(s, e, f, err, ovf);
    #1;
    check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_word"}, bus.out_word, w);
    check({tag, "_flags"}, 32'(bus.out_flags), 32'(fl));
  endtask

  logic [7:0]  bp_e [4];
  logic [23:0] bp_f [4];
  logic        bp_s [4];
  logic [31:0] bp_w [4];
  logic [2:0]  bp_fl[4];
  int          sent;
  int          got;
  logic        in_x;
  logic        out_x;

  initial begin
    n_total         = 0;
    n_bad           = 0;
    nRESET          = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_sign     = 1'b0;
    bus.in_exp      = 8'h0;
    bus.in_frac     = 24'h0;
    bus.in_error    = 1'b0;
    bus.in_overflow = 1'b0;
    bus.out_ready   = 1'b1;

    #2 nRESET = 1'b0;
    #1;
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_word", bus.out_word, 32'h0);
    check("rst_flags", 32'(bus.out_flags), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRESET = 1'b1;
    @(posedge clk);
    #1;
    check("rel_ready", 32'(bus.in_ready), 32'd1);

    send_one("norm0",  1'b0, 8'd127, 24'hC00000, 1'b0, 1'b0, 32'h3FC00000, 3'b000);
    send_one("norm1",  1'b0, 8'd130, 24'h400000, 1'b0, 1'b0, 32'h40800000, 3'b000);
    send_one("err",    1'b0, 8'd50,  24'h123456, 1'b1, 1'b0, 32'h7FC00000, 3'b100);
    send_one("ovf",    1'b1, 8'd10,  24'h800000, 1'b0, 1'b1, 32'hFF800000, 3'b010);
    send_one("errovf", 1'b1, 8'd10,  24'h800000, 1'b1, 1'b1, 32'h7FC00000, 3'b100);
    send_one("uflow",  1'b0, 8'd3,   24'h000100, 1'b0, 1'b0, 32'h00000000, 3'b001);
    send_one("uf_edge",1'b0, 8'd15,  24'h000100, 1'b0, 1'b0, 32'h00000000, 3'b001);
    send_one("min_nrm",1'b0, 8'd16,  24'h000100, 1'b0, 1'b0, 32'h00800000, 3'b000);
    send_one("zero",   1'b1, 8'd100, 24'h000000, 1'b0, 1'b0, 32'h80000000, 3'b000);
    send_one("exp255", 1'b0, 8'd255, 24'h800000, 1'b0, 1'b0, 32'h7F800000, 3'b010);
    send_one("trunc",  1'b1, 8'd200, 24'hFFFFFF, 1'b0, 1'b0, 32'hE47FFFFF, 3'b000);

    // Backpressure: 4 back-to-back inputs, output stalled until cycle 5.
    bp_s[0] = 1'b0; bp_e[0] = 8'd127; bp_f[0] = 24'hC00000; bp_w[0] = 32'h3FC00000; bp_fl[0] = 3'b000;
    bp_s[1] = 1'b0; bp_e[1] = 8'd130; bp_f[1] = 24'h400000; bp_w[1] = 32'h40800000; bp_fl[1] = 3'b000;
    bp_s[2] = 1'b1; bp_e[2] = 8'd200; bp_f[2] = 24'hFFFFFF; bp_w[2] = 32'hE47FFFFF; bp_fl[2] = 3'b000;
    bp_s[3] = 1'b0; bp_e[3] = 8'd3;   bp_f[3] = 24'h000100; bp_w[3] = 32'h00000000; bp_fl[3] = 3'b001;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 20 && got < 4; cyc++) begin
      @(negedge clk);
      bus.out_ready = (cyc >= 5);
      if (sent < 4) drive(bp_s[sent], bp_e[sent], bp_f[sent], 1'b0, 1'b0);
      else bus.in_valid = 1'b0;
      #1;
      if (cyc == 2) check("bp_accepted", 32'(sent), 32'd2);
      if (cyc >= 2 && cyc < 5) begin
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_hold", bus.out_word, bp_w[0]);
      end
      in_x  = bus.in_valid && bus.in_ready;
      out_x = bus.out_valid && bus.out_ready;
      if (out_x) begin
        check("bp_word", bus.out_word, bp_w[got]);
        check("bp_flags", 32'(bus.out_flags), 32'(bp_fl[got]));
        got++;
      end
      @(posedge clk);
      if (in_x) sent++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("bp_count", 32'(got), 32'd4);
    @(posedge clk);
    #1;
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Reset with both stages full.
    @(negedge clk);
    bus.out_ready = 1'b0;
    drive(1'b0, 8'd127, 24'hC00000, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 8'd130, 24'h400000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check("rs_full_valid", 32'(bus.out_valid), 32'd1);
    check("rs_full_ready", 32'(bus.in_ready), 32'd0);
    #2 nRESET = 1'b0;
    #1;
    check("rs_valid", 32'(bus.out_valid), 32'd0);
    check("rs_word", bus.out_word, 32'h0);
    check("rs_flags", 32'(bus.out_flags), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRESET        = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rs_rel_ready", 32'(bus.in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("rs_stale", 32'(bus.out_valid), 32'd0);
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
